_div_impl: RTL and testbench
============================

# _div_impl

Iterative 32-bit integer divider for the s3_execute stage, sitting beside the combinational comparison ops in op_impl. Each step computes one quotient bit with a restoring trial subtraction, which is a partial-remainder ≥ divisor compare. The block accepts one operation at a time under a start/busy/done handshake and returns quotient and remainder with RISC-V M-extension semantics. The execute stage can kill an operation in flight on a pipeline flush.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU; captured with start.
- a  in  32  dividend; captured with start.
- b  in  32  divisor; captured with start.
- kill  in  1  abort the current operation; no done is produced.
- busy  out  1  operation in progress; start is ignored while high.
- done  out  1  one-cycle pulse; quot/rem are valid in this cycle.
- quot  out  32  quotient; held until the next accepted start.
- rem  out  32  remainder; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - capture the operands;
  - convert to magnitudes when is_signed (negate a negative operand);
  - record sign_q = a[31]^b[31] and sign_r = a[31] (signed only);
  - clear the partial remainder, load the quotient shift register with |a|, set count=31;
  - go to CALC.
- CALC, one bit per cycle:
  - form the 33-bit trial value {r[31:0], q[31]} − {1'b0, |b|};
  - if it is non-negative, r takes the trial value and shifts in quotient bit 1; otherwise r is only shifted and the quotient bit is 0.
  - After the count=0 iteration, go to FIX. CALC lasts exactly 32 cycles.
- FIX:
  - negate the quotient if sign_q, negate the remainder if sign_r;
  - register the results into quot/rem; go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Special results:
  - divide by zero (b=0): quot=0xFFFFFFFF, rem=a, in both signed and unsigned modes.
  - signed overflow (a=0x80000000, b=0xFFFFFFFF, signed): quot=0x80000000, rem=0.
- kill:
  - In CALC, FIX or DONE, kill forces IDLE on the next edge and suppresses done.
  - quot/rem keep their prior values.
  - kill in IDLE has no effect. kill has priority over start in the same cycle.
- start while busy=1 is ignored; no queuing.

## Timing
- Reset values: state=IDLE, busy=0, done=0, quot=0, rem=0. Reset mid-operation abandons the operation with no done.
- Cycle 0 is the edge where start is sampled in IDLE.
- Default latency:
  - busy=1 in cycles 1–34;
  - CALC in cycles 1–32, FIX in cycle 33;
  - done=1 in cycle 34;
  - busy=0 in cycle 35, and a new start is accepted in cycle 35.
- busy is high in CALC, FIX and DONE.
- quot/rem change only at the FIX→DONE edge.

## Configuration
- DIV_EARLY_OUT_EN:
  - Defined: divide by zero, signed overflow, and |a| < |b| (quot=0, rem=a) skip CALC, going IDLE→FIX→DONE with done in cycle 2.
  - Undefined: every operation takes the full 34-cycle path.
- Results are identical in both builds.

## Structure
- Shared execute package holds:
  - the state enum type div_state_t;
  - constants DIV_ITERS=32, DIV_OVF_DIVIDEND=32'h80000000, DIV_BYZERO_QUOT=32'hFFFFFFFF.
- One natural sub-module, _div_step: the combinational single-iteration trial-subtract and shift. Input is (r, q, divisor); outputs are the next r and next q.

## Test plan
- Unsigned 100/7, start at cycle 0 → done in cycle 34, quot=14, rem=2, busy high cycles 1–34.
- Signed −7/2 (0xFFFFFFF9, 2) → quot=0xFFFFFFFD (−3), rem=0xFFFFFFFF (−1).
- Divide by zero 5/0, unsigned and signed → quot=0xFFFFFFFF, rem=5. Latency is 34 cycles without DIV_EARLY_OUT_EN and 2 cycles with it.
- Signed 0x80000000/0xFFFFFFFF → quot=0x80000000, rem=0; unsigned with the same operands → quot=0, rem=0x80000000.
- Kill and restart:
  - kill in cycle 10 of a 100/7 operation → busy=0 in cycle 11, no done, quot/rem unchanged;
  - a start asserted simultaneously with that kill is ignored.
  - A start in cycle 11 is accepted normally.
- Reset and ignored start:
  - rst asserted asynchronously in cycle 20 → all outputs are 0 immediately, no done afterwards;
  - start pulsed during busy → ignored, and the first result is unaffected.

Source files
------------

// File: rtl/_div_impl_pkg.sv
// Shared execute-stage definitions for the iterative divider.
// Contents:
//   div_state_t      - divider FSM state encoding (IDLE, CALC, FIX, DONE)
//   DIV_ITERS        - quotient bits produced, one per CALC cycle
//   DIV_OVF_DIVIDEND - most negative dividend, the signed-overflow operand
//   DIV_BYZERO_QUOT  - quotient returned for a zero divisor
package _div_impl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int          DIV_ITERS        = 32;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] DIV_BYZERO_QUOT  = 32'hFFFF_FFFF;

endpackage

// File: rtl/_div_impl_if.sv
// Request/response bundle between the execute stage and the divider.
// Signals:
//   start, is_signed, a, b, kill  - request side (driven by master)
//   busy, done, quot, rem         - response side (driven by slave)
// Modports: master (execute stage), slave (divider).
interface _div_impl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            is_signed;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;

  modport master (
    output start, is_signed, a, b, kill,
    input  busy, done, quot, rem
  );

  modport slave (
    input  start, is_signed, a, b, kill,
    output busy, done, quot, rem
  );
endinterface

// File: rtl/_div_impl_step.sv
// _div_step: one restoring-division iteration, purely combinational.
// Ports:
//   r_i  partial remainder        q_i  quotient/dividend shift register
//   d_i  divisor magnitude        r_o  next partial remainder
//   q_o  next shift register (dividend bit shifted out, quotient bit in)
module _div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] r_o,
  output logic [XLEN-1:0] q_o
);
  // r < d always holds, so a non-negative trial fits in XLEN bits and the
  // extra top bit is purely the borrow.
  logic [XLEN:0] trial;

  assign trial = {r_i, q_i[XLEN-1]} - {1'b0, d_i};

  always_comb begin
    r_o = {r_i[XLEN-2:0], q_i[XLEN-1]};
    q_o = {q_i[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      r_o = trial[XLEN-1:0];
      q_o = {q_i[XLEN-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/_div_impl.sv
// _div_impl: iterative 32-bit divider with RISC-V M-extension results.
// One quotient bit per cycle by restoring trial subtraction; start/busy/done
// handshake, kill aborts an operation in flight without producing done.
// Ports:
//   clk  clock              rst  asynchronous active-high reset
//   bus  _div_impl_if.slave (start, is_signed, a, b, kill -> busy, done, quot, rem)
// Build option:
//   DIV_EARLY_OUT_EN - divide-by-zero, signed overflow and |a| < |b| bypass
//                      CALC (done two cycles after start). Results are
//                      identical with or without it.
module _div_impl
  import _div_impl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  _div_impl_if.slave  bus
);
  localparam int CW = $clog2(DIV_ITERS);

  div_state_t      state_q;
  logic [CW-1:0]   count_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] quot_q, rem_q;
  logic            sign_q_q, sign_r_q, byzero_q, ovf_q;
`ifdef DIV_EARLY_OUT_EN
  logic            small_q;
`endif

  // Datapath state is not reset; it is always reloaded on an accepted start.
  logic [XLEN-1:0] r_q, q_q, d_q, a_q;
  logic [XLEN-1:0] r_nx, q_nx;

  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            accept, byzero_in, ovf_in;
  logic [XLEN-1:0] fix_quot, fix_rem;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign a_s       = bus.a;
  assign b_s       = bus.b;
  assign abs_a     = cond_neg(bus.a, bus.is_signed && (a_s < 0));
  assign abs_b     = cond_neg(bus.b, bus.is_signed && (b_s < 0));
  // kill wins over a simultaneous start
  assign accept    = (state_q == IDLE) && bus.start && !bus.kill;
  assign byzero_in = (bus.b == '0);
  assign ovf_in    = bus.is_signed && (bus.a == DIV_OVF_DIVIDEND) && (bus.b == '1);

  _div_step #(.XLEN(XLEN)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_nx),
    .q_o (q_nx)
  );

  // Sign fix-up and special-case overrides. Overflow falls out of the plain
  // path too (|a|/1 with sign_q=0), but an early-out operation never ran
  // CALC, so the overrides must not depend on q_q/r_q.
  always_comb begin
    fix_quot = cond_neg(q_q, sign_q_q);
    fix_rem  = cond_neg(r_q, sign_r_q);
    if (byzero_q) begin
      fix_quot = DIV_BYZERO_QUOT;
      fix_rem  = a_q;
    end else if (ovf_q) begin
      fix_quot = DIV_OVF_DIVIDEND;
      fix_rem  = '0;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (small_q) begin
      fix_quot = '0;
      fix_rem  = a_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      r_q <= '0;
      q_q <= abs_a;
      d_q <= abs_b;
      a_q <= bus.a;
    end else if (state_q == CALC) begin
      r_q <= r_nx;
      q_q <= q_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      byzero_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      small_q  <= 1'b0;
`endif
    end else if (bus.kill && (state_q != IDLE)) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            sign_q_q <= bus.is_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            sign_r_q <= bus.is_signed && bus.a[XLEN-1];
            byzero_q <= byzero_in;
            ovf_q    <= ovf_in;
            count_q  <= CW'(DIV_ITERS - 1);
            busy_q   <= 1'b1;
            state_q  <= CALC;
`ifdef DIV_EARLY_OUT_EN
            small_q  <= (abs_a < abs_b);
            if (byzero_in || ovf_in || (abs_a < abs_b)) begin
              state_q <= FIX;
            end
`endif
          end
        end
        CALC: begin
          count_q <= count_q - 1'b1;
          if (count_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q  <= fix_quot;
          rem_q   <= fix_rem;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
endmodule

// File: tb/tb__div_impl.sv
// Directed testbench for _div_impl. Expected quotients, remainders and
// latencies are hand-computed; the short-path latency depends on
// DIV_EARLY_OUT_EN.
module tb__div_impl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  _div_impl_if #(.XLEN(32)) bus ();

  _div_impl #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam int FULL_LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int SHORT_LAT = 2;
`else
  localparam int SHORT_LAT = 34;
`endif

  // Issue one operation from a point #1 after a rising edge. Returns the
  // cycle in which done was seen (-1 on timeout) and the results, and
  // counts cycles before done where busy was not high. On return the bench
  // is #1 into cycle lat+1. A nonzero poke pulses an unrelated start in
  // that cycle, which must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int poke,
                        output int lat, output logic [31:0] q,
                        output logic [31:0] r, output int busy_bad);
    bus.a = a; bus.b = b; bus.is_signed = s; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; busy_bad = 0; q = 'x; r = 'x;
    for (int c = 1; c <= 60; c++) begin
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) begin
        lat = c; q = bus.quot; r = bus.rem;
        break;
      end
      if (c == poke) begin
        bus.a = 32'h0000_1234; bus.b = 32'h0000_0005;
        bus.is_signed = 1'b0; bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.is_signed = 1'b0;
    bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.quot !== 32'h0) $display("FAIL reset_quot: got %h expected 0", bus.quot); else pass_cnt++;
    total_cnt++; if (bus.rem !== 32'h0) $display("FAIL reset_rem: got %h expected 0", bus.rem); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Table-driven scenario: each row is a, b, signed, quot, rem, latency.
  typedef struct {
    string       nm;
    logic [31:0] a, b;
    logic        s;
    logic [31:0] eq, er;
    int          elat;
  } vec_t;

  task automatic test_vectors(input string grp, input vec_t v[$]);
    int lat, bb;
    logic [31:0] q, r;
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].s, 0, lat, q, r, bb);
      total_cnt++; if (q !== v[i].eq) $display("FAIL %s/%s quot: got %h expected %h", grp, v[i].nm, q, v[i].eq); else pass_cnt++;
      total_cnt++; if (r !== v[i].er) $display("FAIL %s/%s rem: got %h expected %h", grp, v[i].nm, r, v[i].er); else pass_cnt++;
      total_cnt++; if (lat !== v[i].elat) $display("FAIL %s/%s latency: got %0d expected %0d", grp, v[i].nm, lat, v[i].elat); else pass_cnt++;
      total_cnt++; if (bb !== 0) $display("FAIL %s/%s busy_during: got %0d low cycles expected 0", grp, v[i].nm, bb); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL %s/%s idle_after: got busy=%b done=%b expected 0 0", grp, v[i].nm, bus.busy, bus.done); else pass_cnt++;
    end
  endtask

  task automatic test_unsigned();
    vec_t v[$];
    v.push_back('{"100_7",   32'd100,       32'd7,     1'b0, 32'd14,        32'd2,   FULL_LAT});
    v.push_back('{"max_16",  32'hFFFF_FFFF, 32'h10,    1'b0, 32'h0FFF_FFFF, 32'hF,   FULL_LAT});
    v.push_back('{"big_div", 32'hFFFF_FFFE, 32'h8000_0001, 1'b0, 32'd1,     32'h7FFF_FFFD, FULL_LAT});
    test_vectors("unsigned", v);
  endtask

  task automatic test_signed();
    vec_t v[$];
    v.push_back('{"m7_2",   32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, FULL_LAT});
    v.push_back('{"7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         FULL_LAT});
    v.push_back('{"m7_m2",  32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF, FULL_LAT});
    test_vectors("signed", v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{"div0_u",   32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         SHORT_LAT});
    v.push_back('{"div0_s",   32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 32'd5,         SHORT_LAT});
    v.push_back('{"div0_sneg",32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, SHORT_LAT});
    v.push_back('{"ovf_s",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         SHORT_LAT});
    v.push_back('{"ovf_u",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, SHORT_LAT});
    v.push_back('{"small_s",  32'd3,         32'hFFFF_FFF6, 1'b1, 32'd0,         32'd3,         SHORT_LAT});
    v.push_back('{"small_sn", 32'hFFFF_FFFD, 32'd10,        1'b1, 32'd0,         32'hFFFF_FFFD, SHORT_LAT});
    test_vectors("special", v);
  endtask

  task automatic test_kill();
    int lat, bb;
    logic [31:0] q, r;
    // Establish known held results: 9/4 = 2 r 1.
    run_op(32'd9, 32'd4, 1'b0, 0, lat, q, r, bb);
    total_cnt++; if (q !== 32'd2 || r !== 32'd1) $display("FAIL kill_setup: got %h/%h expected 2/1", q, r); else pass_cnt++;
    // Start 200/3; we are now #1 into cycle 1 after the start edge.
    bus.a = 32'd200; bus.b = 32'd3; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    // Cycle 10: kill together with a competing start.
    bus.kill = 1'b1; bus.start = 1'b1; bus.a = 32'd50; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.kill = 1'b0; bus.start = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL kill_busy: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL kill_done: got %b expected 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.quot !== 32'd2) $display("FAIL kill_quot_held: got %h expected 2", bus.quot); else pass_cnt++;
    total_cnt++; if (bus.rem !== 32'd1) $display("FAIL kill_rem_held: got %h expected 1", bus.rem); else pass_cnt++;
    // Cycle 11: restart is accepted.
    run_op(32'd100, 32'd7, 1'b0, 0, lat, q, r, bb);
    total_cnt++; if (q !== 32'd14) $display("FAIL restart_quot: got %h expected e", q); else pass_cnt++;
    total_cnt++; if (r !== 32'd2) $display("FAIL restart_rem: got %h expected 2", r); else pass_cnt++;
    total_cnt++; if (lat !== FULL_LAT) $display("FAIL restart_latency: got %0d expected %0d", lat, FULL_LAT); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    bus.a = 32'd1000; bus.b = 32'd3; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.quot !== 32'd0) $display("FAIL rstmid_quot: got %h expected 0", bus.quot); else pass_cnt++;
    total_cnt++; if (bus.rem !== 32'd0) $display("FAIL rstmid_rem: got %h expected 0", bus.rem); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    total_cnt++; if (dones !== 0) $display("FAIL rstmid_no_done: got %0d active cycles expected 0", dones); else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    int lat, bb;
    logic [31:0] q, r;
    run_op(32'd100, 32'd7, 1'b0, 5, lat, q, r, bb);
    total_cnt++; if (q !== 32'd14) $display("FAIL ignstart_quot: got %h expected e", q); else pass_cnt++;
    total_cnt++; if (r !== 32'd2) $display("FAIL ignstart_rem: got %h expected 2", r); else pass_cnt++;
    total_cnt++; if (lat !== FULL_LAT) $display("FAIL ignstart_latency: got %0d expected %0d", lat, FULL_LAT); else pass_cnt++;
    total_cnt++; if (bb !== 0) $display("FAIL ignstart_busy: got %0d low cycles expected 0", bb); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL ignstart_not_queued: got busy=%b expected 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back('{"1000_10", 32'd1000,      32'd10, 1'b0, 32'd100,       32'd0,         FULL_LAT});
    v.push_back('{"m100_7",  32'hFFFF_FF9C, 32'd7,  1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, FULL_LAT});
    v.push_back('{"0_9",     32'd0,         32'd9,  1'b1, 32'd0,         32'd0,         SHORT_LAT});
    test_vectors("b2b", v);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_kill();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end
endmodule
